// File: rtl/heartbeat_pkg.sv
// Shared constants and state encoding for the heartbeat animation sequencer.
package heartbeat_pkg;

    localparam int HB_CNT_W     = 4;
    localparam int HB_LAST_STEP = 11;

    typedef enum logic [1:0] {
        HB_IDLE  = 2'd0,
        HB_RUN   = 2'd1,
        HB_PAUSE = 2'd2
    } hb_state_t;

endpackage

// File: rtl/hb_prescaler.sv
// Programmable step prescaler: counts base clocks and flags when the current
// speed-dependent limit has been reached.
module hb_prescaler #(
    parameter int TICK_DIV = 12_500_000,
    parameter int DIV_W    = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       run,
    input  logic [1:0] speed,
    output logic       adv
);

    localparam logic [DIV_W-1:0] TICK_DIV_W = DIV_W'(TICK_DIV);

    logic [DIV_W-1:0] presc_reg;
    logic [DIV_W-1:0] presc_next;
    logic [DIV_W-1:0] limit;
    logic [DIV_W-1:0] limit_m1;

    always_comb begin
        limit    = TICK_DIV_W >> speed;
        limit_m1 = limit - DIV_W'(1);
    end

    // Greater-or-equal so a drop to a shorter limit fires at once instead of wrapping.
    assign adv = (presc_reg >= limit_m1);

    always_comb begin
        presc_next = presc_reg;
        if (clr) begin
            presc_next = '0;
        end else if (run) begin
            presc_next = adv ? '0 : presc_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

endmodule

// File: rtl/heartbeat_sequencer.sv
// Animation step generator for the heartbeat segment decoder: run/pause/idle
// control, single stepping and registered tick/beat strobes.
module heartbeat_sequencer
    import heartbeat_pkg::*;
#(
    parameter int TICK_DIV  = 12_500_000,
    parameter int DIV_W     = 24,
    parameter int LAST_STEP = HB_LAST_STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clear,
    input  logic                step,
    input  logic [1:0]          speed,
    output logic [HB_CNT_W-1:0] cnt,
    output logic                tick,
    output logic                beat,
    output logic                running
);

    localparam logic [HB_CNT_W-1:0] LAST_CNT = HB_CNT_W'(LAST_STEP);

    hb_state_t           state_reg, state_next;
    logic [HB_CNT_W-1:0] cnt_reg, cnt_next;
    logic                tick_reg, tick_next;
    logic                beat_reg, beat_next;
    logic                running_reg;
    logic                presc_adv;
    logic                presc_run;
    logic                presc_clr;
    logic                advance;
    logic                wrap;

    // On the pausing edge the prescaler holds unless it is completing a step.
    assign presc_run = (state_reg == HB_RUN) && (en || presc_adv);
    assign presc_clr = clear || (state_reg == HB_IDLE);

    hb_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .run   (presc_run),
        .speed (speed),
        .adv   (presc_adv)
    );

    always_comb begin
        state_next = state_reg;
        advance    = 1'b0;
        if (clear) begin
            state_next = HB_IDLE;
        end else begin
            case (state_reg)
                HB_IDLE: begin
                    if (en) state_next = HB_RUN;
                end
                HB_RUN: begin
                    advance = presc_adv;
                    if (!en) state_next = HB_PAUSE;
                end
                HB_PAUSE: begin
                    if (en) state_next = HB_RUN;
                    else if (step) advance = 1'b1;
                end
                default: state_next = HB_IDLE;
            endcase
        end
    end

    // Out-of-range values are treated as a wrap so the sequence recovers.
    assign wrap = (cnt_reg >= LAST_CNT);

    always_comb begin
        cnt_next  = cnt_reg;
        tick_next = 1'b0;
        beat_next = 1'b0;
        if (clear || state_reg == HB_IDLE) begin
            cnt_next = '0;
        end else if (advance) begin
            cnt_next  = wrap ? '0 : cnt_reg + HB_CNT_W'(1);
            tick_next = 1'b1;
            beat_next = wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= HB_IDLE;
            cnt_reg     <= '0;
            tick_reg    <= 1'b0;
            beat_reg    <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            tick_reg    <= tick_next;
            beat_reg    <= beat_next;
            running_reg <= (state_next == HB_RUN);
        end
    end

    assign cnt     = cnt_reg;
    assign tick    = tick_reg;
    assign beat    = beat_reg;
    assign running = running_reg;

endmodule

// File: tb/tb_heartbeat_sequencer.sv
// Self-checking bench: directed scenarios followed by random control traffic,
// every cycle compared against a behavioural model of the step sequence.
module tb_heartbeat_sequencer;

    localparam int TICK_DIV = 8;
    localparam int DIV_W    = 4;
    localparam int LAST     = 11;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       clear = 1'b0;
    logic       step  = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [3:0] cnt;
    logic       tick;
    logic       beat;
    logic       running;

    int num_checks = 0;
    int num_errors = 0;

    // Model: mode 0 idle, 1 run, 2 pause; elapsed = cycles spent in the current step.
    int m_mode    = 0;
    int m_elapsed = 0;
    int m_cnt     = 0;
    int m_tick    = 0;
    int m_beat    = 0;

    always #5 clk = ~clk;

    heartbeat_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .DIV_W     (DIV_W),
        .LAST_STEP (LAST)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clear   (clear),
        .step    (step),
        .speed   (speed),
        .cnt     (cnt),
        .tick    (tick),
        .beat    (beat),
        .running (running)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int period;
        int fire;
        fire = 0;
        if (!rst_n || clear) begin
            m_mode    = 0;
            m_elapsed = 0;
            m_cnt     = 0;
        end else begin
            period = TICK_DIV / (1 << speed);
            if (m_mode == 0) begin
                if (en) m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_elapsed + 1 >= period) begin
                    fire      = 1;
                    m_elapsed = 0;
                end else if (en) begin
                    m_elapsed = m_elapsed + 1;
                end
                if (!en) m_mode = 2;
            end else begin
                if (en) m_mode = 1;
                else if (step) fire = 1;
            end
        end
        m_tick = fire;
        m_beat = (fire != 0 && m_cnt == LAST) ? 1 : 0;
        if (fire != 0) m_cnt = (m_cnt + 1) % (LAST + 1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        $display("t=%0t rst_n=%0b en=%0b step=%0b clr=%0b spd=%0d | cnt=%0d tick=%0b beat=%0b run=%0b",
                 $time, rst_n, en, step, clear, speed, cnt, tick, beat, running);
        check_value("cnt", 32'(cnt), 32'(m_cnt));
        check_value("tick", 32'(tick), 32'(m_tick));
        check_value("beat", 32'(beat), 32'(m_beat));
        check_value("running", 32'(running), (m_mode == 1) ? 32'd1 : 32'd0);
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (2) cycle();
        check_value("rst_cnt", 32'(cnt), 32'd0);
        check_value("rst_running", 32'(running), 32'd0);

        // Start running: first tick after exactly 8 cycles in RUN
        rst_n = 1'b1;
        en    = 1'b1;
        cycle();
        check_value("start_running", 32'(running), 32'd1);
        check_value("start_cnt", 32'(cnt), 32'd0);
        repeat (7) cycle();
        check_value("pre_first_tick", 32'(tick), 32'd0);
        cycle();
        check_value("first_cnt", 32'(cnt), 32'd1);
        check_value("first_tick", 32'(tick), 32'd1);

        // Wrap 11 -> 0 with beat
        repeat (87) cycle();
        check_value("pre_wrap_cnt", 32'(cnt), 32'd11);
        cycle();
        check_value("wrap_cnt", 32'(cnt), 32'd0);
        check_value("wrap_beat", 32'(beat), 32'd1);

        // Pause at cnt=3 with prescaler 5
        repeat (24) cycle();
        check_value("cnt3", 32'(cnt), 32'd3);
        repeat (5) cycle();
        en = 1'b0;
        cycle();
        repeat (20) cycle();
        check_value("pause_hold_cnt", 32'(cnt), 32'd3);
        check_value("pause_running", 32'(running), 32'd0);

        step = 1'b1;
        cycle();
        step = 1'b0;
        check_value("step_cnt", 32'(cnt), 32'd4);
        check_value("step_tick", 32'(tick), 32'd1);

        // en and step together: en wins
        en   = 1'b1;
        step = 1'b1;
        cycle();
        step = 1'b0;
        check_value("en_step_running", 32'(running), 32'd1);
        check_value("en_step_cnt", 32'(cnt), 32'd4);
        repeat (2) cycle();
        check_value("resume_no_early", 32'(cnt), 32'd4);
        cycle();
        check_value("resume_cnt", 32'(cnt), 32'd5);
        check_value("resume_tick", 32'(tick), 32'd1);

        // Speed change with prescaler at 6
        repeat (6) cycle();
        speed = 2'd2;
        cycle();
        check_value("speed_fire_cnt", 32'(cnt), 32'd6);
        cycle();
        check_value("speed_gap_tick", 32'(tick), 32'd0);
        cycle();
        check_value("speed_next_cnt", 32'(cnt), 32'd7);

        // Clear coincident with an advance
        cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check_value("clear_cnt", 32'(cnt), 32'd0);
        check_value("clear_tick", 32'(tick), 32'd0);
        check_value("clear_running", 32'(running), 32'd0);

        // Reset while paused
        en = 1'b1;
        repeat (5) cycle();
        en = 1'b0;
        cycle();
        step = 1'b1;
        cycle();
        step = 1'b0;
        check_value("pre_rst_cnt", 32'(cnt), 32'd3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_value("pause_rst_cnt", 32'(cnt), 32'd0);
        check_value("pause_rst_tick", 32'(tick), 32'd0);
        check_value("pause_rst_running", 32'(running), 32'd0);

        // Random control traffic
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 9) < 7);
            step  = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 199) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/heartbeat_sequencer.md
Name: heartbeat_sequencer

Overview:
- Upstream driver of the heartbeat 7-segment decoder. Generates the 4-bit animation step (0..11) that the decoder maps to segment patterns.
- Contains a programmable prescaler, a run/pause/idle state machine, single-step support and beat/tick strobes.
- Sits between the board clock and the segment decoder. Its cnt output connects directly to the decoder's cnt input.

Parameters:
- TICK_DIV, 12_500_000: base clock cycles per step at speed=0 (4 steps/s at 50 MHz); must be ≥ 8.
- DIV_W, 24: prescaler counter width; must satisfy 2^DIV_W > TICK_DIV.
- LAST_STEP, 11: final step index before wrap to 0; must be ≤ 15.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  level: 1 = run, 0 = pause.
- clear  in  1  synchronous clear to IDLE; priority below rst_n, above all else.
- step  in  1  single-cycle pulse; advances one step while PAUSE.
- speed  in  2  prescaler limit = TICK_DIV >> speed (x1, x2, x4, x8 faster).
- cnt  out  4  current animation step 0..LAST_STEP; feeds the segment decoder.
- tick  out  1  one-cycle pulse, high in the cycle cnt presents a newly advanced value.
- beat  out  1  one-cycle pulse, high with tick when cnt wrapped LAST_STEP->0.
- running  out  1  high while state = RUN.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low. All outputs are registered.
- Reset values (rst_n=0 at an edge): state=IDLE, cnt=0, prescaler=0, tick=0, beat=0, running=0.
- IDLE: cnt=0, prescaler=0. step is ignored. en=1 -> RUN.
- RUN: the prescaler increments every cycle. When prescaler ≥ limit-1:
  - prescaler <= 0 and cnt advances.
  - Compare is ≥ so that a speed change mid-count (e.g. to a smaller limit) fires on the next cycle and never overshoots.
  - en=0 -> PAUSE. On that edge the prescaler and cnt hold; if the advance condition is also true that edge, the advance still happens.
- PAUSE: prescaler and cnt hold.
  - step=1 advances cnt once. The prescaler is unchanged.
  - en=1 -> RUN and the prescaler resumes from its held value.
  - If en=1 and step=1 arrive together, en wins: go to RUN, step is ignored.
- clear=1 (any state) -> IDLE with the reset values on the next edge. A pending advance is dropped; tick and beat stay 0.
- Advance rule: cnt <= (cnt == LAST_STEP) ? 0 : cnt+1.
  - tick <= 1 on that edge.
  - beat <= 1 only on the wrap.
  - Otherwise tick and beat are 0.
- Out-of-range recovery: if cnt > LAST_STEP (defensive), the next advance forces cnt to 0 with beat=1.
- running is registered and equals (next state == RUN).
- Latency:
  - en rising in IDLE: first tick after exactly limit cycles in RUN.
  - step in PAUSE: cnt and tick update one edge later.
- Width: limit is computed at DIV_W bits. speed shifts never underflow below 1 given TICK_DIV ≥ 8.

Decomposition:
- Package heartbeat_pkg holds:
  - HB_CNT_W=4 and HB_LAST_STEP=11.
  - State enum hb_state_t {HB_IDLE, HB_RUN, HB_PAUSE}, 2-bit binary encoding.
- One sub-module: hb_prescaler.
  - Inputs: clk, rst_n, clr, run, speed.
  - Output: adv pulse.
  - Parameterised by TICK_DIV and DIV_W. Contains the ≥ compare and the hold-on-!run logic.
- The top holds the FSM, cnt, tick, beat and running.

Test Plan (TICK_DIV=8, DIV_W=4):
- Reset and run: rst_n=0 for 2 cycles, then en=1, speed=0 -> cnt=0 and running=1; cnt=1 with tick after 8 cycles; cnt steps every 8 cycles.
- Wrap: run 12 steps -> cnt 11->0 with tick=1 and beat=1 in the same cycle; beat=0 on all other ticks.
- Pause and step: pause at cnt=3 mid-count (prescaler=5); 20 idle cycles -> cnt holds at 3.
  - step pulse -> cnt=4 with tick one edge later.
  - en=1 -> next advance after 3 cycles (prescaler resumed from 5).
- Simultaneous en and step in PAUSE at cnt=4 -> state RUN, cnt stays 4 (step ignored).
- Speed change: in RUN with prescaler=6, set speed=2 (limit 2) -> advance on the next edge, then every 2 cycles.
- Clear and reset mid-operation: clear at cnt=7 coincident with an advance -> cnt=0, tick=0, running=0, IDLE.
  - rst_n=0 during PAUSE -> all outputs 0 at the next edge.
